// File: rtl/elevator_request_ctrl.sv
// Request stage in front of the elevator car FSM: latches calls, answers
// the Delay/FR_Delay handshakes and offers destination/direction hints.
module elevator_request_ctrl #(
  parameter int DOOR_CYCLES = 8,
  parameter int DOOR_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_up,
  input  logic [3:0] call_dn,
  input  logic [3:0] cab_btn,
  input  logic [1:0] Actual_Stage,
  input  logic       UD_Answer,
  input  logic       STOP,
  input  logic       Delay,
  input  logic       FR_Delay,
  input  logic [2:0] Solicitud_stage,
  output logic [2:0] next_stage,
  output logic       OC_Request,
  output logic       UD_Request,
  output logic       NO_STOP,
  output logic       DoneDelay,
  output logic       DoneFRDelay
);

  typedef enum logic [2:0] {
    IDLE, ARR, WAITD, DOOR, FRACK, FRWAIT
  } state_t;

  localparam logic [DOOR_W-1:0] LOAD = DOOR_W'(DOOR_CYCLES);
  localparam logic [DOOR_W-1:0] ONE  = DOOR_W'(1);

  state_t            state, state_n;
  logic [DOOR_W-1:0] cnt, cnt_n;
  logic [3:0]        up_p, dn_p, cab_p;
  logic [3:0]        up_n, dn_n, cab_n;
  logic [3:0]        up_clr, dn_clr, cab_clr;
  logic              fr_seen;
  logic              fr_new;

  logic [3:0] fmask;
  logic       end_floor;
  logic       up_sel, dn_sel;
  logic [3:0] hit_up, hit_dn, hit_cab;
  logic [3:0] prs_up, prs_dn, prs_cab;
  logic [3:0] here_up, here_dn, here_cab;
  logic       hit, press, here_any;

  logic [3:0] pend, above, below;
  logic [2:0] ns_d;
  logic       oc_d, ud_d, nostop_d, dd_d, dfr_d;

  assign fmask     = 4'b0001 << Actual_Stage;
  assign end_floor = (Actual_Stage == 2'd0) | (Actual_Stage == 2'd3);
  assign up_sel    = UD_Answer | end_floor;
  assign dn_sel    = ~UD_Answer | end_floor;

  assign hit_up  = up_p & fmask & {4{up_sel}};
  assign hit_dn  = dn_p & fmask & {4{dn_sel}};
  assign hit_cab = cab_p & fmask;
  assign hit     = |{hit_up, hit_dn, hit_cab};

  assign prs_up  = call_up & 4'b0111 & fmask & {4{up_sel}};
  assign prs_dn  = call_dn & 4'b1110 & fmask & {4{dn_sel}};
  assign prs_cab = cab_btn & fmask;
  assign press   = |{prs_up, prs_dn, prs_cab};

  assign here_up  = up_p & fmask;
  assign here_dn  = dn_p & fmask;
  assign here_cab = cab_p & fmask;
  assign here_any = |{here_up, here_dn, here_cab};

  // fr_seen blocks a second ack of a FR_Delay level still held after FRACK
  assign fr_new = FR_Delay & ~fr_seen;

  assign up_n  = (up_p | (call_up & 4'b0111)) & ~up_clr;
  assign dn_n  = (dn_p | (call_dn & 4'b1110)) & ~dn_clr;
  assign cab_n = (cab_p | cab_btn) & ~cab_clr;

  function automatic logic [2:0] nearest(
    input logic [3:0] p,
    input logic [1:0] f,
    input logic       up
  );
    logic [2:0] nu, nd;
    nu = '0;
    nd = '0;
    for (int i = 3; i >= 0; i--)
      if (i > int'(f) && p[i]) nu = 3'(i + 1);
    for (int i = 0; i < 4; i++)
      if (i < int'(f) && p[i]) nd = 3'(i + 1);
    if (up) return (nu != 3'd0) ? nu : nd;
    else    return (nd != 3'd0) ? nd : nu;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      up_p        <= '0;
      dn_p        <= '0;
      cab_p       <= '0;
      fr_seen     <= 1'b0;
      next_stage  <= '0;
      OC_Request  <= 1'b0;
      UD_Request  <= 1'b0;
      NO_STOP     <= 1'b0;
      DoneDelay   <= 1'b0;
      DoneFRDelay <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      up_p        <= up_n;
      dn_p        <= dn_n;
      cab_p       <= cab_n;
      if (state == FRACK) fr_seen <= 1'b1;
      else if (!FR_Delay) fr_seen <= 1'b0;
      next_stage  <= ns_d;
      OC_Request  <= oc_d;
      UD_Request  <= ud_d;
      NO_STOP     <= nostop_d;
      DoneDelay   <= dd_d;
      DoneFRDelay <= dfr_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    up_clr  = '0;
    dn_clr  = '0;
    cab_clr = '0;
    unique case (state)
      IDLE: begin
        if (Delay) state_n = ARR;
        else if (fr_new) state_n = FRACK;
        else if (STOP && here_any) begin
          state_n = DOOR;
          cnt_n   = LOAD;
          up_clr  = here_up;
          dn_clr  = here_dn;
          cab_clr = here_cab;
        end
      end
      ARR: begin
        up_clr  = hit_up;
        dn_clr  = hit_dn;
        cab_clr = hit_cab;
        if (hit) begin
          state_n = DOOR;
          cnt_n   = LOAD;
        end else begin
          state_n = WAITD;
        end
      end
      WAITD: if (!Delay) state_n = IDLE;
      DOOR: begin
        if (press) begin
          cnt_n   = LOAD;
          up_clr  = prs_up;
          dn_clr  = prs_dn;
          cab_clr = prs_cab;
        end else if (!fr_new) begin
          cnt_n = cnt - ONE;
        end
        if (fr_new) state_n = FRACK;
        else if (!press && cnt <= ONE) begin
          state_n = WAITD;
          cnt_n   = '0;
        end
      end
      FRACK: begin
        if (Solicitud_stage != 3'd0 && Solicitud_stage <= 3'd4)
          cab_clr = 4'b0001 << (Solicitud_stage - 3'd1);
        state_n = (cnt != '0) ? DOOR : FRWAIT;
      end
      FRWAIT: if (!FR_Delay) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pend  = up_n | dn_n | cab_n;
    above = '0;
    below = '0;
    for (int i = 0; i < 4; i++) begin
      above[i] = (i > int'(Actual_Stage));
      below[i] = (i < int'(Actual_Stage));
    end
    ns_d     = nearest(cab_n, Actual_Stage, UD_Answer);
    ud_d     = (|(pend & above)) & (UD_Answer | ~(|(pend & below)));
    nostop_d = STOP & (|(pend & ~fmask));
    oc_d     = (state_n == DOOR) |
               ((state_n == FRACK) && (cnt_n != '0));
    dd_d     = (state_n == ARR);
    dfr_d    = (state_n == FRACK);
  end

endmodule
